// File: rtl/int_log_issuer.sv
// int_log_issuer: issues one logic command at a time to the 16-bit logic
// unit, waits a fixed latency, captures the result and returns it over a
// valid/ready response channel. The illegal opcode 111 is answered locally
// with an error response and never reaches the unit.
module int_log_issuer #(
  parameter int WIDTH = 16,
  parameter int LAT   = 2   // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [2:0]       operation,
  output logic [WIDTH-1:0] opa_log,
  output logic [WIDTH-1:0] opb_log,
  input  logic [WIDTH-1:0] out_log,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [15:0]      issue_count
);

  localparam logic [2:0] OP_ILLEGAL = 3'b111;
  localparam logic [3:0] WAIT_INIT  = 4'(LAT - 1);

  // BOOT keeps cmd_ready low through reset and for the release cycle.
  typedef enum logic [1:0] {ST_BOOT, ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       wait_cnt_reg, wait_cnt_next;
  logic [2:0]       operation_reg, operation_next;
  logic [WIDTH-1:0] opa_reg, opa_next;
  logic [WIDTH-1:0] opb_reg, opb_next;
  logic [WIDTH-1:0] rsp_data_reg, rsp_data_next;
  logic             rsp_err_reg, rsp_err_next;
  logic [15:0]      issue_count_reg, issue_count_next;

  // State and datapath registers; reset discards any in-flight command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_BOOT;
      wait_cnt_reg    <= '0;
      operation_reg   <= '0;
      opa_reg         <= '0;
      opb_reg         <= '0;
      rsp_data_reg    <= '0;
      rsp_err_reg     <= 1'b0;
      issue_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      wait_cnt_reg    <= wait_cnt_next;
      operation_reg   <= operation_next;
      opa_reg         <= opa_next;
      opb_reg         <= opb_next;
      rsp_data_reg    <= rsp_data_next;
      rsp_err_reg     <= rsp_err_next;
      issue_count_reg <= issue_count_next;
    end
  end

  // Next-state and next-value logic; everything holds unless a transition updates it.
  always_comb begin
    state_next       = state_reg;
    wait_cnt_next    = wait_cnt_reg;
    operation_next   = operation_reg;
    opa_next         = opa_reg;
    opb_next         = opb_reg;
    rsp_data_next    = rsp_data_reg;
    rsp_err_next     = rsp_err_reg;
    issue_count_next = issue_count_reg;
    case (state_reg)
      ST_BOOT: state_next = ST_IDLE;
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_op != OP_ILLEGAL) begin
            operation_next   = cmd_op;
            opa_next         = cmd_a;
            opb_next         = cmd_b;
            wait_cnt_next    = WAIT_INIT;
            issue_count_next = issue_count_reg + 16'd1;
            state_next       = ST_WAIT;
          end else begin
            // Unit operands stay untouched; the error is answered locally.
            rsp_data_next = '0;
            rsp_err_next  = 1'b1;
            state_next    = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_reg != 4'd0) begin
          wait_cnt_next = wait_cnt_reg - 4'd1;
        end else begin
          rsp_data_next = out_log;
          rsp_err_next  = 1'b0;
          state_next    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign cmd_ready   = (state_reg == ST_IDLE);
  assign rsp_valid   = (state_reg == ST_RESP);
  assign operation   = operation_reg;
  assign opa_log     = opa_reg;
  assign opb_log     = opb_reg;
  assign rsp_data    = rsp_data_reg;
  assign rsp_err     = rsp_err_reg;
  assign issue_count = issue_count_reg;

endmodule
